// File: rtl/lut_table_loader.sv
// Writer side of the sparse interpolation LUT: keeps every 4th sample of a
// 256-sample stream as an anchor and tracks the worst linear-interpolation error.
module lut_table_loader #(
  parameter logic [7:0] ERR_LIMIT = 8'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       s_valid_i,
  input  logic [7:0] s_data_i,
  output logic       s_ready_o,
  output logic       wr_en_o,
  output logic [5:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] max_err_o,
  output logic       err_flag_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] anchor_q, anchor_d;
  logic [7:0] f0_q, f0_d;
  logic [7:0] buf1_q, buf1_d;
  logic [7:0] buf2_q, buf2_d;
  logic [7:0] buf3_q, buf3_d;
  logic       wr_en_q, wr_en_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] max_err_q, max_err_d;
  logic       err_flag_q, err_flag_d;

  logic       accept_s;
  logic [7:0] seg_b_s;
  logic [7:0] err1_s, err2_s, err3_s;
  logic [7:0] seg_max_s;

  // |s - (a + floor((b-a)*k/4))|, evaluated in 11-bit two's complement
  function automatic logic [7:0] seg_err(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] s,
    input logic [1:0] k
  );
    logic signed [10:0] diff;
    logic signed [10:0] kw;
    logic signed [10:0] prod;
    logic signed [10:0] shf;
    logic signed [10:0] est;
    logic signed [10:0] dlt;
    logic signed [10:0] mag;
    diff = {3'd0, b} - {3'd0, a};
    kw   = {9'd0, k};
    prod = diff * kw;
    shf  = prod >>> 2;
    est  = $signed({3'd0, a}) + shf;
    dlt  = $signed({3'd0, s}) - est;
    mag  = dlt[10] ? -dlt : dlt;
    return (|mag[10:8]) ? 8'hFF : mag[7:0];
  endfunction

  function automatic logic [7:0] max2(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? x : y;
  endfunction

  assign accept_s = (state_q == ST_LOAD) && s_valid_i;
  // In TAIL the closing anchor wraps back to sample 0
  assign seg_b_s  = (state_q == ST_TAIL) ? f0_q : s_data_i;
  assign err1_s   = seg_err(anchor_q, seg_b_s, buf1_q, 2'd1);
  assign err2_s   = seg_err(anchor_q, seg_b_s, buf2_q, 2'd2);
  assign err3_s   = seg_err(anchor_q, seg_b_s, buf3_q, 2'd3);
  assign seg_max_s = max2(err1_s, max2(err2_s, err3_s));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    anchor_d   = anchor_q;
    f0_d       = f0_q;
    buf1_d     = buf1_q;
    buf2_d     = buf2_q;
    buf3_d     = buf3_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    max_err_d  = max_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_LOAD;
          cnt_d     = 8'd0;
          max_err_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          cnt_d = cnt_q + 8'd1;
          case (cnt_q[1:0])
            2'd0: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cnt_q[7:2];
              wr_data_d = s_data_i;
              anchor_d  = s_data_i;
              if (cnt_q == 8'd0) begin
                f0_d = s_data_i;
              end else begin
                max_err_d = max2(max_err_q, seg_max_s);
              end
            end
            2'd1:    buf1_d = s_data_i;
            2'd2:    buf2_d = s_data_i;
            default: buf3_d = s_data_i;
          endcase
          if (cnt_q == 8'd255) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_TAIL: begin
        max_err_d = max2(max_err_q, seg_max_s);
        state_d   = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    err_flag_d = (max_err_d > ERR_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      anchor_q   <= 8'd0;
      f0_q       <= 8'd0;
      buf1_q     <= 8'd0;
      buf2_q     <= 8'd0;
      buf3_q     <= 8'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 6'd0;
      wr_data_q  <= 8'd0;
      max_err_q  <= 8'd0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      anchor_q   <= anchor_d;
      f0_q       <= f0_d;
      buf1_q     <= buf1_d;
      buf2_q     <= buf2_d;
      buf3_q     <= buf3_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      max_err_q  <= max_err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign s_ready_o  = (state_q == ST_LOAD);
  assign busy_o     = (state_q == ST_LOAD) || (state_q == ST_TAIL);
  assign done_o     = (state_q == ST_DONE);
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign max_err_o  = max_err_q;
  assign err_flag_o = err_flag_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Scoreboard bench for lut_table_loader: a driver pushes expected LUT writes and
// final error results computed from the table; a monitor pops them as the DUT emits.
module tb_lut_table_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       s_valid_i;
  logic [7:0] s_data_i;
  logic       s_ready_o;
  logic       wr_en_o;
  logic [5:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] max_err_o;
  logic       err_flag_o;

  always #5 clk = ~clk;

  lut_table_loader #(.ERR_LIMIT(8'd8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_ready_o (s_ready_o),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .max_err_o (max_err_o),
    .err_flag_o(err_flag_o)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int merr; int flag; } res_t;

  wr_t  wq[$];
  res_t rq[$];
  int   tbl[256];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // floor(n/4) for any sign
  function automatic int floor4(input int n);
    if (n >= 0) return n / 4;
    return -((-n + 3) / 4);
  endfunction

  // Reference: every 4th sample is kept; dropped samples are compared to the
  // straight line between neighbouring kept samples, last segment wraps to sample 0.
  task automatic model_push(input int abort_after);
    int merr;
    merr = 0;
    for (int j = 0; j < 64; j++) begin
      int a, b;
      a = tbl[4*j];
      b = tbl[(4*j + 4) % 256];
      if (abort_after == 0 || 4*j < abort_after) begin
        wr_t w;
        w.addr = j;
        w.data = a;
        wq.push_back(w);
      end
      for (int k = 1; k < 4; k++) begin
        int est, e;
        est = a + floor4((b - a) * k);
        e = tbl[4*j + k] - est;
        if (e < 0) e = -e;
        if (e > merr) merr = e;
      end
    end
    if (abort_after == 0) begin
      res_t r;
      r.merr = merr;
      r.flag = (merr > 8) ? 1 : 0;
      rq.push_back(r);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0: tbl[i] = i;
        1: tbl[i] = 8'h80;
        2: tbl[i] = 13;
        default: tbl[i] = $urandom_range(255, 0);
      endcase
    end
    if (mode == 2) begin
      tbl[1] = 12; tbl[2] = 11; tbl[3] = 11; tbl[4] = 10;
      tbl[5] = 10; tbl[6] = 11; tbl[7] = 12;
    end
    if (mode == 4) begin
      // smooth random walk, small interpolation errors
      tbl[0] = 128;
      for (int i = 1; i < 256; i++) tbl[i] = tbl[i-1] + $urandom_range(2, 0) - 1;
      tbl[255] = tbl[0];
    end
  endtask

  task automatic run_load(input int mode, input bit gaps, input bit midstart, input int abort_after);
    int i, cyc, lim;
    bit acc;
    fill(mode);
    model_push(abort_after);
    lim = (abort_after == 0) ? 256 : abort_after;
    // samples offered in IDLE must not be taken
    s_valid_i = 1'b1;
    s_data_i  = 8'hAA;
    @(negedge clk);
    check("idle_s_ready", s_ready_o, 0);
    @(posedge clk); #1;
    s_valid_i = 1'b0;
    start_i   = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    i = 0;
    cyc = 0;
    while (i < lim && cyc < 4000) begin
      s_valid_i = gaps ? cyc[0] : 1'b1;
      s_data_i  = tbl[i][7:0];
      start_i   = midstart && (cyc == 50 || cyc == 51);
      @(negedge clk);
      acc = s_valid_i && s_ready_o;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    start_i   = 1'b0;
    s_valid_i = 1'b0;
    check("accept_count", i, lim);
    if (abort_after != 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_s_ready", s_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_wr_en", wr_en_o, 0);
      check("rst_max_err", max_err_o, 0);
      check("rst_writes_left", wq.size(), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      check("tail_busy", busy_o, 1);
      check("tail_done", done_o, 0);
      @(negedge clk);
      check("done_pulse", done_o, 1);
      check("done_busy", busy_o, 0);
      @(negedge clk);
      check("done_single", done_o, 0);
      check("results_left", rq.size(), 0);
      check("writes_left", wq.size(), 0);
    end
  endtask

  // Monitor: compare every DUT write and completion against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en_o) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", wr_addr_o, w.addr);
          check("wr_data", wr_data_o, w.data);
        end
      end
      if (done_o) begin
        if (rq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          res_t r;
          r = rq.pop_front();
          check("max_err", max_err_o, r.merr);
          check("err_flag", err_flag_o, r.flag);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    start_i   = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = 8'd0;
    @(negedge clk);
    check("reset_s_ready", s_ready_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_wr_en", wr_en_o, 0);
    check("reset_wr_addr", wr_addr_o, 0);
    check("reset_wr_data", wr_data_o, 0);
    check("reset_max_err", max_err_o, 0);
    check("reset_err_flag", err_flag_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_load(0, 1'b0, 1'b0, 0);
    check("ramp_hold_max_err", max_err_o, 192);
    run_load(1, 1'b0, 1'b0, 0);
    run_load(2, 1'b0, 1'b0, 0);
    run_load(0, 1'b1, 1'b1, 0);
    run_load(3, 1'b0, 1'b0, 100);
    run_load(0, 1'b0, 1'b0, 0);
    run_load(3, 1'b1, 1'b0, 0);
    run_load(4, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_table_loader.md
# lut_table_loader

Writer side of the 64-entry interpolation LUT. It accepts a 256-sample function table as a valid/ready stream and keeps every 4th sample (index multiple of 4) as an anchor, writing it to the sparse LUT write port. It also measures the worst-case linear-interpolation error of the 192 dropped samples, using the interpolating reader's addressing, including its wrap from entry 63 to entry 0. It sits between the table source (host/ROM streamer) and the sparse LUT RAM.

## Interface
- ERR_LIMIT, 8, error threshold; err_flag asserts when max_err > ERR_LIMIT
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE
- s_valid  in  1  sample valid
- s_data  in  8  unsigned sample, streamed in index order 0..255
- s_ready  out  1  loader accepts a sample; transfer = s_valid & s_ready
- wr_en  out  1  sparse LUT write strobe
- wr_addr  out  6  sparse LUT address (sample index >> 2)
- wr_data  out  8  anchor value
- busy  out  1  high in LOAD and TAIL
- done  out  1  one-cycle pulse; load and error scan complete
- max_err  out  8  maximum absolute interpolation error, unsigned
- err_flag  out  1  max_err > ERR_LIMIT

## Operation
- States: IDLE -> LOAD on start. LOAD -> TAIL on acceptance of sample 255. TAIL -> DONE unconditionally. DONE -> IDLE unconditionally.
- start in IDLE clears cnt, max_err and err_flag. start in any other state is ignored.
- s_ready = 1 only in LOAD. cnt[7:0] counts accepted samples and increments per transfer.
- Anchor accept (cnt[1:0]==0):
  - Register wr_en=1, wr_addr=cnt[7:2], wr_data=s_data.
  - Store the value as current anchor A. For cnt==0, also store it as F0.
- Dropped accept (cnt[1:0]=k, k=1..3): store the value in buf[k].
- Segment evaluation, done when anchor B is accepted with cnt!=0, using the previous anchor A:
  - diff = B - A, signed 9-bit.
  - interp_k = A + ((diff*k) >>> 2), arithmetic shift (floor), 11-bit signed product. The result is always in 0..255.
  - err_k = |buf[k] - interp_k|, for k=1..3, all three in parallel.
  - max_err <= max(max_err, err_1, err_2, err_3).
- TAIL: evaluates the final segment with A=anchor 63, B=F0 (6-bit address wrap), and buf = samples 253..255. Same rule.
- err_flag is combinational from max_err, or registered equivalently.
- Reset mid-load:
  - All state and outputs return to reset values and the FSM goes to IDLE.
  - Entries already written stay in the LUT. No rollback.
  - A new start performs a complete reload.

## Timing
- Reset values: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, max_err=0, err_flag=0, state=IDLE, cnt=0.
- wr_en is high for exactly the cycle after each accepted anchor. There are exactly 64 writes per load, addresses 0..63 in order.
- max_err is updated on the edge after an anchor accept (cnt!=0), and on the TAIL edge.
- Sample 255 accepted at edge N:
  - busy is high through TAIL, i.e. the cycle after edge N.
  - done is high for the single cycle after edge N+1, and busy=0 in that cycle.
  - max_err and err_flag are final while done=1 and hold until the next start or reset.
- s_valid may drop at any time. Gaps only stretch the load and never change results.
- Minimum load time: 256 cycles of transfers + TAIL + DONE.

## Test plan
- Ramp s_data=i, s_valid=1 continuously:
  - 64 writes, wr_addr=a, wr_data=4a.
  - Tail segment A=252, B=0 gives interp 189, 126, 63 against actual 253, 254, 255.
  - Result: max_err=192, err_flag=1, done one cycle after TAIL.
- Constant 0x80 table -> all wr_data=0x80, max_err=0, err_flag=0.
- Floor rounding:
  - Stimulus: all samples 13, except samples 1..7 = 12, 11, 11, 10, 10, 11, 12.
  - Segment 0 interp = 12, 11, 10, giving errors 0, 0, 1. Segment 1 interp = 10, 11, 12, giving error 0.
  - Result: max_err=1, err_flag=0, wr_data at address 1 = 10.
- Ramp with s_valid toggling every cycle, and start pulsed again mid-load -> identical writes, max_err=192, start ignored, s_valid ignored while in IDLE.
- rst_n low after 100 accepts:
  - Immediately s_ready=0, busy=0, wr_en=0, max_err=0.
  - After a new start plus the full ramp, results match the first scenario.
